// File: rtl/rv_pkg.sv
// Shared RV32I definitions used by the data-memory responder and the core
// control path: load/store funct3 encodings, the major opcodes that produce
// memory accesses, and the responder FSM state encoding.
package rv_pkg;

  // Major opcodes that generate mem_read / mem_write in the control path.
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings.
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Responder FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/rv_dmem_if.sv
// Request/response bundle between the core (master) and rv_dmem (slave).
//
// Handshake: a request transfers on a rising clk edge where req_valid_i,
// req_ready_o and (mem_read_i | mem_write_i) are all high; request fields
// must be stable while req_valid_i is high. The response is a one-cycle
// strobe on resp_valid_o with no back-pressure; rdata_o and err_o are only
// meaningful while resp_valid_o is high.
//
// Signals: req_valid_i, req_ready_o, mem_read_i, mem_write_i, funct3_i[2:0],
// addr_i[31:0], wdata_i[31:0], resp_valid_o, rdata_o[31:0], err_o.
interface rv_dmem_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        resp_valid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport slave (
    input  req_valid_i, mem_read_i, mem_write_i, funct3_i, addr_i, wdata_i,
    output req_ready_o, resp_valid_o, rdata_o, err_o
  );

  modport master (
    output req_valid_i, mem_read_i, mem_write_i, funct3_i, addr_i, wdata_i,
    input  req_ready_o, resp_valid_o, rdata_o, err_o
  );
endinterface

// File: rtl/rv_dmem_lane.sv
// Combinational byte-lane logic for rv_dmem.
// Ports:
//   is_store_i  : 1 = store access, 0 = load access
//   funct3_i    : RV32I load/store size/sign encoding
//   addr_lo_i   : byte offset within the word (addr[1:0])
//   wdata_i     : right-aligned store data
//   raw_i       : current contents of the addressed word
//   be_o        : byte enables for the store (0 when bad)
//   wdata_o     : store data replicated onto the addressed lanes
//   rdata_o     : extended load result (0 when bad)
//   bad_o       : misaligned access or undefined funct3
module rv_dmem_lane
  import rv_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] raw_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        bad_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
    be_o     = 4'b0000;
    wdata_o  = 32'h0;
    rdata_o  = 32'h0;
    bad_o    = 1'b0;

    if (is_store_i) begin
      // Replicating the data puts the right bytes on every candidate lane;
      // the byte enables then pick which lanes are actually written.
      unique case (funct3_i)
        F3_SB: begin
          be_o    = 4'b0001 << addr_lo_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        F3_SH: begin
          bad_o   = addr_lo_i[0];
          be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{wdata_i[15:0]}};
        end
        F3_SW: begin
          bad_o   = |addr_lo_i;
          be_o    = 4'b1111;
          wdata_o = wdata_i;
        end
        default: bad_o = 1'b1;
      endcase
    end else begin
      unique case (funct3_i)
        F3_LB:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
        F3_LBU: rdata_o = {24'h0, byte_sel};
        F3_LH: begin
          bad_o   = addr_lo_i[0];
          rdata_o = {{16{half_sel[15]}}, half_sel};
        end
        F3_LHU: begin
          bad_o   = addr_lo_i[0];
          rdata_o = {16'h0, half_sel};
        end
        F3_LW: begin
          bad_o   = |addr_lo_i;
          rdata_o = raw_i;
        end
        default: bad_o = 1'b1;
      endcase
    end

    if (bad_o) begin
      be_o    = 4'b0000;
      rdata_o = 32'h0;
    end
  end

endmodule

// File: rtl/rv_dmem.sv
// RV32I data-memory responder. Accepts one load/store at a time, waits
// WAIT_CYCLES cycles, performs the access on the edge entering RESP and
// presents a registered one-cycle response.
// Ports:
//   clk         : clock, rising edge
//   rstn        : asynchronous active-low reset
//   bus         : rv_dmem_if slave (request handshake + response strobe)
//   dbg_state_o : current FSM state
// Parameters: DEPTH_WORDS (power of two), WAIT_CYCLES (0..15).
module rv_dmem
  import rv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  rv_dmem_if.slave    bus,
  output dmem_state_e dbg_state_o
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        fire;
  logic        cur_rd, cur_wr;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr, cur_wdata;
  logic [AW-1:0] word_idx;
  logic [31:0] raw_word;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;
  logic        lane_bad;
  logic        access, acc_err, mem_we;
  logic        unused_addr_bits;

  assign fire = bus.req_valid_i & ready_q & (bus.mem_read_i | bus.mem_write_i);

  // With zero wait states the access happens on the acceptance edge itself,
  // before the latch holds anything, so IDLE uses the live request fields.
  assign cur_rd    = (state_q == ST_IDLE) ? bus.mem_read_i  : rd_q;
  assign cur_wr    = (state_q == ST_IDLE) ? bus.mem_write_i : wr_q;
  assign cur_f3    = (state_q == ST_IDLE) ? bus.funct3_i    : f3_q;
  assign cur_addr  = (state_q == ST_IDLE) ? bus.addr_i      : addr_q;
  assign cur_wdata = (state_q == ST_IDLE) ? bus.wdata_i     : wdata_q;

  // Upper address bits are dropped, so addresses alias modulo the array size.
  assign word_idx         = cur_addr[AW+1:2];
  assign unused_addr_bits = ^cur_addr[31:AW+2];
  assign raw_word         = mem[word_idx];

  rv_dmem_lane u_lane (
    .is_store_i (cur_wr),
    .funct3_i   (cur_f3),
    .addr_lo_i  (cur_addr[1:0]),
    .wdata_i    (cur_wdata),
    .raw_i      (raw_word),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata),
    .bad_o      (lane_bad)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    rdata_d      = 32'h0;
    err_d        = 1'b0;
    access       = 1'b0;
    acc_err      = 1'b0;
    mem_we       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fire) begin
          rd_d    = bus.mem_read_i;
          wr_d    = bus.mem_write_i;
          f3_d    = bus.funct3_i;
          addr_d  = bus.addr_i;
          wdata_d = bus.wdata_i;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_RESP;
            access  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);

    if (access) begin
      acc_err      = lane_bad | (cur_rd & cur_wr);
      resp_valid_d = 1'b1;
      err_d        = acc_err;
      rdata_d      = (!acc_err && cur_rd) ? lane_rdata : 32'h0;
      mem_we       = !acc_err && cur_wr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      f3_q         <= 3'd0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Storage is not reset. A reset mid-operation forces state_q to IDLE, and
  // ready_q is low during reset, so mem_we cannot fire for a discarded request.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_be[b]) mem[word_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
      end
    end
  end

  assign bus.req_ready_o  = ready_q;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.rdata_o      = rdata_q;
  assign bus.err_o        = err_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_rv_dmem.sv
module tb_rv_dmem;
  import rv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  rv_dmem_if b1 ();
  rv_dmem_if b0 ();
  dmem_state_e st1, st0;

  rv_dmem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rstn(rstn), .bus(b1.slave), .dbg_state_o(st1));
  rv_dmem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rstn(rstn), .bus(b0.slave), .dbg_state_o(st0));

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp0_q[$];
  time         exp0_t[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon1
    logic [32:0] e;
    if (b1.resp_valid_o === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_resp1", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("resp1_err", b1.err_o, e[32]);
        check("resp1_rdata", b1.rdata_o, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin : mon0
    logic [32:0] e;
    time t;
    if (b0.resp_valid_o === 1'b1) begin
      if (exp0_q.size() == 0) check("unexpected_resp0", 1, 0);
      else begin
        e = exp0_q.pop_front();
        t = exp0_t.pop_front();
        check("resp0_err", b0.err_o, e[32]);
        check("resp0_rdata", b0.rdata_o, e[31:0]);
        check("resp0_latency", $time, t);
      end
    end
  end

  // ---------------- driver (WAIT_CYCLES = 1 instance) ----------------
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd, input bit want_resp);
    int  k;
    time t_acc;
    bit  seen;
    k = 0;
    @(negedge clk);
    while (b1.req_ready_o !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) check("ready_timeout", 0, 1);
    b1.req_valid_i = 1'b1;
    b1.mem_read_i  = rd;
    b1.mem_write_i = wr;
    b1.funct3_i    = f3;
    b1.addr_i      = a;
    b1.wdata_i     = wd;
    if (want_resp) exp_q.push_back({e_err, e_rd});
    @(posedge clk);
    t_acc = $time;
    #1;
    b1.req_valid_i = 1'b0;
    b1.mem_read_i  = 1'b0;
    b1.mem_write_i = 1'b0;
    if (want_resp) begin
      @(negedge clk);
      check("ready_busy", b1.req_ready_o, 0);
      k = 0;
      while (b1.resp_valid_o !== 1'b1 && k < 40) begin @(negedge clk); k++; end
      // accepted at t_acc, WAIT for one cycle, RESP sampled mid next cycle
      check("resp_latency", $time - t_acc, 15);
      @(negedge clk);
      check("resp_one_cycle", b1.resp_valid_o, 0);
      check("ready_after_resp", b1.req_ready_o, 1);
    end else begin
      seen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (b1.resp_valid_o !== 1'b0) seen = 1'b1;
      end
      check("no_resp", seen, 0);
      check("still_ready", b1.req_ready_o, 1);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] model [8];
  time         acc_t [4];
  logic [31:0] d0, d1;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int k, w, l;
    logic [31:0] e;
    logic        t_rd [4];
    logic        t_wr [4];
    logic [31:0] t_a  [4];
    logic [31:0] t_wd [4];
    logic [31:0] t_e  [4];

    b1.req_valid_i = 0; b1.mem_read_i = 0; b1.mem_write_i = 0;
    b1.funct3_i = 0; b1.addr_i = 0; b1.wdata_i = 0;
    b0.req_valid_i = 0; b0.mem_read_i = 0; b0.mem_write_i = 0;
    b0.funct3_i = 0; b0.addr_i = 0; b0.wdata_i = 0;

    // reset state
    #1;
    check("rst_ready", b1.req_ready_o, 0);
    check("rst_resp", b1.resp_valid_o, 0);
    check("rst_err", b1.err_o, 0);
    check("rst_rdata", b1.rdata_o, 0);
    check("rst_ready0", b0.req_ready_o, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1 check("ready_before_edge", b1.req_ready_o, 0);
    @(posedge clk); #1;
    check("ready_after_release", b1.req_ready_o, 1);

    // word round trip
    issue(0, 1, F3_SW, 32'h40, 32'hDEADBEEF, 0, 0, 1);
    issue(1, 0, F3_LW, 32'h40, 0, 0, 32'hDEADBEEF, 1);

    // byte / half lanes
    issue(0, 1, F3_SW, 32'h80, 32'h11223344, 0, 0, 1);
    issue(0, 1, F3_SB, 32'h81, 32'hFFFFFFA5, 0, 0, 1);
    issue(1, 0, F3_LW,  32'h80, 0, 0, 32'h1122A544, 1);
    issue(1, 0, F3_LB,  32'h81, 0, 0, 32'hFFFFFFA5, 1);
    issue(1, 0, F3_LBU, 32'h81, 0, 0, 32'h000000A5, 1);
    issue(1, 0, F3_LH,  32'h82, 0, 0, 32'h00001122, 1);
    issue(1, 0, F3_LHU, 32'h82, 0, 0, 32'h00001122, 1);
    issue(0, 1, F3_SH,  32'h82, 32'h00008BCD, 0, 0, 1);
    issue(1, 0, F3_LH,  32'h82, 0, 0, 32'hFFFF8BCD, 1);
    issue(1, 0, F3_LHU, 32'h82, 0, 0, 32'h00008BCD, 1);
    issue(1, 0, F3_LB,  32'h83, 0, 0, 32'hFFFFFF8B, 1);
    issue(1, 0, F3_LW,  32'h80, 0, 0, 32'h8BCDA544, 1);

    // errors
    issue(1, 0, F3_LW, 32'h42, 0, 1, 0, 1);
    issue(1, 0, F3_LH, 32'h81, 0, 1, 0, 1);
    issue(0, 1, F3_SH, 32'h43, 32'h00005555, 1, 0, 1);
    issue(0, 1, F3_SW, 32'h42, 32'h66666666, 1, 0, 1);
    issue(1, 0, F3_LW, 32'h40, 0, 0, 32'hDEADBEEF, 1);
    issue(1, 0, 3'b011, 32'h40, 0, 1, 0, 1);
    issue(1, 0, 3'b110, 32'h40, 0, 1, 0, 1);
    issue(0, 1, 3'b011, 32'h40, 32'h0, 1, 0, 1);
    issue(0, 1, 3'b100, 32'h40, 32'h0, 1, 0, 1);
    issue(1, 1, F3_SW, 32'h40, 32'h77777777, 1, 0, 1);
    issue(1, 0, F3_LW, 32'h40, 0, 0, 32'hDEADBEEF, 1);
    issue(0, 0, F3_SW, 32'h40, 32'h88888888, 0, 0, 0);
    issue(1, 0, F3_LW, 32'h40, 0, 0, 32'hDEADBEEF, 1);

    // address wrap
    issue(0, 1, F3_SW, 32'h1000, 32'hCAFEF00D, 0, 0, 1);
    issue(1, 0, F3_LW, 32'h0, 0, 0, 32'hCAFEF00D, 1);

    // reset in the middle of a store's wait state
    issue(0, 1, F3_SW, 32'h10, 32'h0BADF00D, 0, 0, 1);
    @(negedge clk);
    k = 0;
    while (b1.req_ready_o !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    b1.req_valid_i = 1; b1.mem_read_i = 0; b1.mem_write_i = 1;
    b1.funct3_i = F3_SW; b1.addr_i = 32'h10; b1.wdata_i = 32'h12345678;
    @(posedge clk); #1;
    b1.req_valid_i = 0; b1.mem_write_i = 0;
    check("mid_state_wait", st1, ST_WAIT);
    rstn = 1'b0;
    #1;
    check("mid_rst_ready", b1.req_ready_o, 0);
    @(posedge clk); @(negedge clk);
    check("mid_rst_resp", b1.resp_valid_o, 0);
    check("mid_rst_err", b1.err_o, 0);
    check("mid_rst_rdata", b1.rdata_o, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready_back", b1.req_ready_o, 1);
    issue(1, 0, F3_LW, 32'h10, 0, 0, 32'h0BADF00D, 1);

    // zero wait states: 1-cycle latency, back-to-back acceptance every 2 cycles
    d0 = $urandom; d1 = $urandom;
    t_rd[0] = 0; t_wr[0] = 1; t_a[0] = 32'h20; t_wd[0] = d0; t_e[0] = 0;
    t_rd[1] = 1; t_wr[1] = 0; t_a[1] = 32'h20; t_wd[1] = 0;  t_e[1] = d0;
    t_rd[2] = 0; t_wr[2] = 1; t_a[2] = 32'h24; t_wd[2] = d1; t_e[2] = 0;
    t_rd[3] = 1; t_wr[3] = 0; t_a[3] = 32'h24; t_wd[3] = 0;  t_e[3] = d1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      k = 0;
      while (b0.req_ready_o !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      if (k >= 20) check("ready0_timeout", 0, 1);
      b0.req_valid_i = 1; b0.mem_read_i = t_rd[i]; b0.mem_write_i = t_wr[i];
      b0.funct3_i = F3_SW; b0.addr_i = t_a[i]; b0.wdata_i = t_wd[i];
      if (t_rd[i]) b0.funct3_i = F3_LW;
      exp0_q.push_back({1'b0, t_e[i]});
      @(posedge clk);
      acc_t[i] = $time;
      exp0_t.push_back($time + 5);
    end
    @(negedge clk);
    b0.req_valid_i = 0; b0.mem_read_i = 0; b0.mem_write_i = 0;
    for (int i = 1; i < 4; i++) check("b2b_spacing", acc_t[i] - acc_t[i-1], 20);
    repeat (3) @(negedge clk);

    // random word stores, then random byte loads against a shadow model
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      issue(0, 1, F3_SW, 32'h200 + 32'(4*i), model[i], 0, 0, 1);
    end
    for (int i = 0; i < 12; i++) begin
      w = int'($urandom_range(0, 7));
      l = int'($urandom_range(0, 3));
      e = (model[w] >> (8*l)) & 32'hFF;
      issue(1, 0, F3_LBU, 32'h200 + 32'(4*w + l), 0, 0, e, 1);
    end

    repeat (4) @(negedge clk);
    check("queue1_drain", exp_q.size(), 0);
    check("queue0_drain", exp0_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
